// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers (ID/EX, EX/MEM, MEM/WB).
// Control bundle bit offsets and the common two-slot stage state.
package pipe_pkg;

    localparam int unsigned CTRL_JUMP       = 9;
    localparam int unsigned CTRL_BRANCH     = 8;
    localparam int unsigned CTRL_REGW       = 7;
    localparam int unsigned CTRL_ALUSRC     = 6;
    localparam int unsigned CTRL_ALUCTL_MSB = 5;
    localparam int unsigned CTRL_ALUCTL_LSB = 2;
    localparam int unsigned CTRL_MEMW       = 1;
    localparam int unsigned CTRL_RESSRC     = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-slot valid/ready skid register with synchronous flush.
// Bits set in CLEAR_MASK are zeroed in any slot that is empty or squashed.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] CLEAR_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_state       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, pop;

    always_comb begin
        accept  = in_valid & in_ready_q & ~flush;
        pop     = (state_q != ST_EMPTY) & out_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q & ~CLEAR_MASK;
            skid_d  = skid_q & ~CLEAR_MASK;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_SKID;
                    end else if (pop) begin
                        // vacated main slot must present zero control
                        main_d  = main_q & ~CLEAR_MASK;
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = skid_q & ~CLEAR_MASK;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    main_d  = main_q & ~CLEAR_MASK;
                    skid_d  = skid_q & ~CLEAR_MASK;
                    state_d = ST_EMPTY;
                end
            endcase
        end
        // registered ready: depends only on the next occupancy
        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: skid-buffered handshake, flush with control
// squash, and a saturating count of cycles where EX was ready but starved.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CTRL_W  = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NUM_SRC*XLEN-1:0] in_src,
    input  logic [REG_AW-1:0]       in_rd_addr,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NUM_SRC*XLEN-1:0] out_src,
    output logic [REG_AW-1:0]       out_rd_addr,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_pc,
    output logic [CNT_W-1:0]        bubble_count
);

    localparam int unsigned BUNDLE_W = CTRL_W + NUM_SRC*XLEN + REG_AW + 2*XLEN;
    localparam logic [BUNDLE_W-1:0] CTRL_MASK =
        {{CTRL_W{1'b1}}, {(BUNDLE_W-CTRL_W){1'b0}}};

    logic [BUNDLE_W-1:0] in_bundle, out_bundle;
    logic [CNT_W-1:0]    bubble_q, bubble_d;

    assign in_bundle = {in_ctrl, in_src, in_rd_addr, in_imm, in_pc};
    assign {out_ctrl, out_src, out_rd_addr, out_imm, out_pc} = out_bundle;

    pipe_skid_reg #(
        .WIDTH      (BUNDLE_W),
        .CLEAR_MASK (CTRL_MASK)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bundle)
    );

    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !out_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a depth-2 FIFO reference model predicts
// readiness/validity, accepted entries are queued and popped on each handshake.
module tb_id_ex_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CTRL_W  = 10;
    localparam int unsigned CNT_W   = 4;
    localparam int          BUB_MAX = 15;

    typedef struct packed {
        logic [CTRL_W-1:0]       ctrl;
        logic [NUM_SRC*XLEN-1:0] src;
        logic [REG_AW-1:0]       rd;
        logic [XLEN-1:0]         imm;
        logic [XLEN-1:0]         pc;
    } entry_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [CTRL_W-1:0]       in_ctrl = '0;
    logic [NUM_SRC*XLEN-1:0] in_src = '0;
    logic [REG_AW-1:0]       in_rd_addr = '0;
    logic [XLEN-1:0]         in_imm = '0;
    logic [XLEN-1:0]         in_pc = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [NUM_SRC*XLEN-1:0] out_src;
    logic [REG_AW-1:0]       out_rd_addr;
    logic [XLEN-1:0]         out_imm;
    logic [XLEN-1:0]         out_pc;
    logic [CNT_W-1:0]        bubble_count;

    id_ex_stage #(
        .XLEN    (XLEN),
        .NUM_SRC (NUM_SRC),
        .REG_AW  (REG_AW),
        .CTRL_W  (CTRL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_src       (in_src),
        .in_rd_addr   (in_rd_addr),
        .in_imm       (in_imm),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_src      (out_src),
        .out_rd_addr  (out_rd_addr),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    int     model_cnt = 0;
    int     model_bub = 0;
    bit     mon_en = 1'b0;
    entry_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic [XLEN-1:0] pc, input logic [CTRL_W-1:0] ctrl);
        entry_t e;
        e.ctrl = ctrl;
        e.src  = {$urandom, $urandom};
        e.rd   = REG_AW'($urandom);
        e.imm  = $urandom;
        e.pc   = pc;
        return e;
    endfunction

    // Entered and left at posedge+1; model advances at the edge.
    task automatic cycle(input logic inv, input entry_t e, input logic ordy, input logic fl);
        bit acc;
        int old_cnt;
        in_valid   = inv;
        in_ctrl    = e.ctrl;
        in_src     = e.src;
        in_rd_addr = e.rd;
        in_imm     = e.imm;
        in_pc      = e.pc;
        out_ready  = ordy;
        flush      = fl;
        acc = inv && (model_cnt < 2) && !fl;
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        old_cnt = model_cnt;
        if (ordy && old_cnt == 0 && model_bub < BUB_MAX) model_bub++;
        if (fl) begin
            model_cnt = 0;
            exp_q.delete();
        end else begin
            model_cnt = old_cnt - ((ordy && old_cnt > 0) ? 1 : 0) + (acc ? 1 : 0);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("in_ready", 64'(in_ready), 64'(model_cnt < 2));
            check("out_valid", 64'(out_valid), 64'(model_cnt > 0));
            check("bubble_count", 64'(bubble_count), 64'(model_bub));
            if (!out_valid) check("ctrl_zero_when_idle", 64'(out_ctrl), 64'd0);
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got pc 0x%0h required no entry", out_pc);
                end else begin
                    entry_t w;
                    w = exp_q.pop_front();
                    check("out_pc", 64'(out_pc), 64'(w.pc));
                    check("out_ctrl", 64'(out_ctrl), 64'(w.ctrl));
                    check("out_src", 64'(out_src), 64'(w.src));
                    check("out_rd_addr", 64'(out_rd_addr), 64'(w.rd));
                    check("out_imm", 64'(out_imm), 64'(w.imm));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        entry_t idle;
        idle = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) cycle(0, idle, 0, 0);

        // streaming
        for (int unsigned i = 0; i < 8; i++) cycle(1, mk(XLEN'(i*4), CTRL_W'($urandom)), 1, 0);
        repeat (2) cycle(0, idle, 1, 0);

        // back-pressure into skid, blocked offer while full
        cycle(1, mk(32'h10, CTRL_W'($urandom)), 1, 0);
        cycle(1, mk(32'h14, CTRL_W'($urandom)), 0, 0);
        cycle(1, mk(32'h18, CTRL_W'($urandom)), 0, 0);
        repeat (3) cycle(0, idle, 1, 0);

        // flush while in skid state with a concurrent offer
        cycle(1, mk(32'h30, '1), 0, 0);
        cycle(1, mk(32'h34, '1), 0, 0);
        cycle(1, mk(32'h20, '1), 0, 1);
        repeat (2) cycle(0, idle, 1, 0);

        // control squash on flush and on drain
        cycle(1, mk(32'h40, '1), 0, 0);
        cycle(0, idle, 0, 1);
        cycle(1, mk(32'h44, '1), 0, 0);
        repeat (2) cycle(0, idle, 1, 0);

        // bubble saturation
        repeat (20) cycle(0, idle, 1, 0);
        check("bubble_saturated", 64'(bubble_count), 64'(BUB_MAX));

        // random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, mk(32'h1000 + XLEN'(i*4), CTRL_W'($urandom)),
                  ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        repeat (3) cycle(0, idle, 1, 0);

        // async reset mid-cycle while holding an entry
        cycle(1, mk(32'h50, '1), 0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_bubble", 64'(bubble_count), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        model_cnt = 0;
        model_bub = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int unsigned i = 0; i < 6; i++) cycle(1, mk(32'h60 + XLEN'(i*4), CTRL_W'($urandom)), 1, 0);
        repeat (3) cycle(0, idle, 1, 0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
